// File: rtl/kbd_event_decoder.sv
// PS/2 set-2 scan byte decoder: turns E0/F0 prefixed byte streams into
// make/break events, queues them in a FIFO, counts new key presses in BCD
// and keeps sticky protocol-error and overflow flags.
module kbd_event_decoder #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  input  logic                    rx_overflow,
  input  logic                    clr,
  output logic                    ev_valid,
  output logic [9:0]              ev_data,
  input  logic                    ev_ready,
  output logic [4*CNT_DIGITS-1:0] press_bcd,
  output logic [7:0]              last_code,
  output logic                    last_ext,
  output logic                    key_held,
  output logic                    err,
  output logic                    ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = 4 * CNT_DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [9:0]       mem_q [DEPTH];
  logic [BW-1:0]    bcd_q, bcd_d, bcd_inc;
  logic [7:0]       last_code_q, last_code_d;
  logic             last_ext_q, last_ext_d;
  logic [8:0]       held_q, held_d;
  logic             key_held_q, key_held_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic             full, accept, byte_ok, pop, push;
  logic             make_ev, brk_ev, ev_ext, proto_err, repeat_hit;
  logic [9:0]       push_data;
  logic             carry;
  logic [3:0]       digit;

  assign full      = (count_q == CW'(DEPTH));
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign byte_ok   = accept && !rx_overflow;
  assign ev_valid  = (count_q != '0);
  assign pop       = ev_valid && ev_ready;
  assign ev_data   = ev_valid ? mem_q[rd_ptr_q] : 10'd0;
  assign press_bcd = bcd_q;
  assign last_code = last_code_q;
  assign last_ext  = last_ext_q;
  assign key_held  = key_held_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

  // Prefix FSM: classify each accepted byte as prefix, make, break or error.
  always_comb begin
    state_d   = state_q;
    make_ev   = 1'b0;
    brk_ev    = 1'b0;
    ev_ext    = 1'b0;
    proto_err = 1'b0;
    if (byte_ok) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == 8'hE0)      state_d = S_E0;
          else if (in_data == 8'hF0) state_d = S_F0;
          else                       make_ev = 1'b1;
        end
        S_E0: begin
          if (in_data == 8'hF0)      state_d = S_E0F0;
          else if (in_data == 8'hE0) proto_err = 1'b1;
          else begin
            make_ev = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          if (in_data == 8'hE0 || in_data == 8'hF0) proto_err = 1'b1;
          else begin
            brk_ev = 1'b1;
            ev_ext = (state_q == S_E0F0);
          end
        end
      endcase
    end
    if (rx_overflow) state_d = S_IDLE;
  end

  // BCD +1 with per-digit decimal carry; all-nines wraps to zero.
  always_comb begin
    bcd_inc = bcd_q;
    carry   = 1'b1;
    digit   = 4'd0;
    for (int i = 0; i < int'(CNT_DIGITS); i++) begin
      digit = bcd_q[4*i +: 4];
      if (carry) begin
        if (digit == 4'd9) bcd_inc[4*i +: 4] = 4'd0;
        else begin
          bcd_inc[4*i +: 4] = digit + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Event bookkeeping: typematic filter, FIFO pointers, counter and flags.
  always_comb begin
    repeat_hit  = key_held_q && (held_q == {ev_ext, in_data});
    push        = brk_ev || (make_ev && !repeat_hit);
    push_data   = {brk_ev, ev_ext, in_data};
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    bcd_d       = bcd_q;
    last_code_d = last_code_q;
    last_ext_d  = last_ext_q;
    held_d      = held_q;
    key_held_d  = key_held_q;
    if (make_ev && !repeat_hit) begin
      bcd_d       = bcd_inc;
      last_code_d = in_data;
      last_ext_d  = ev_ext;
      held_d      = {ev_ext, in_data};
      key_held_d  = 1'b1;
    end
    if (brk_ev && (held_q == {ev_ext, in_data})) key_held_d = 1'b0;
    err_d = err_q || proto_err;
    ovf_d = ovf_q || rx_overflow || (in_valid && !in_ready);
    if (clr) begin
      bcd_d = '0;
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bcd_q       <= '0;
      last_code_q <= '0;
      last_ext_q  <= 1'b0;
      held_q      <= '0;
      key_held_q  <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bcd_q       <= bcd_d;
      last_code_q <= last_code_d;
      last_ext_q  <= last_ext_d;
      held_q      <= held_d;
      key_held_q  <= key_held_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  // FIFO storage; contents are qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Bench for kbd_event_decoder: directed vector table, hand sequences for
// FIFO fill and counter wrap, and random traffic against a queue-based model.
module tb_kbd_event_decoder;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned CNT_DIGITS = 3;
  localparam int          MOD        = 1000;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, rx_overflow, clr;
  logic [7:0]  in_data;
  logic        ev_valid, ev_ready;
  logic [9:0]  ev_data;
  logic [11:0] press_bcd;
  logic [7:0]  last_code;
  logic        last_ext, key_held, err, ovf;

  int checks   = 0;
  int failures = 0;

  kbd_event_decoder #(.DEPTH(DEPTH), .CNT_DIGITS(CNT_DIGITS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rx_overflow(rx_overflow), .clr(clr),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
    .press_bcd(press_bcd), .last_code(last_code), .last_ext(last_ext),
    .key_held(key_held), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: prefix flags, event queue, integer press count.
  logic [9:0] m_q[$];
  bit         m_e0, m_f0, m_last_ext, m_held_v, m_err, m_ovf;
  logic [7:0] m_last_code;
  logic [8:0] m_held;
  int         m_cnt;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int          x;
    x = v;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit rst, input bit iv, input logic [7:0] d,
                            input bit rdy, input bit cl, input bit rx);
    bit room, got_make, got_brk, ext;
    if (rst) begin
      m_q.delete();
      {m_e0, m_f0, m_last_ext, m_held_v, m_err, m_ovf} = '0;
      m_last_code = '0;
      m_held      = '0;
      m_cnt       = 0;
      return;
    end
    room     = (m_q.size() < DEPTH);
    got_make = 1'b0;
    got_brk  = 1'b0;
    ext      = 1'b0;
    if (iv && !room) m_ovf = 1'b1;
    if (rx) begin
      m_ovf = 1'b1;
      m_e0  = 1'b0;
      m_f0  = 1'b0;
    end else if (iv && room) begin
      if (d == 8'hE0) begin
        if (m_f0) begin m_err = 1'b1; m_e0 = 1'b0; m_f0 = 1'b0; end
        else if (m_e0) m_err = 1'b1;
        else m_e0 = 1'b1;
      end else if (d == 8'hF0) begin
        if (m_f0) begin m_err = 1'b1; m_e0 = 1'b0; m_f0 = 1'b0; end
        else m_f0 = 1'b1;
      end else begin
        ext = m_e0;
        if (m_f0) got_brk = 1'b1;
        else got_make = 1'b1;
        m_e0 = 1'b0;
        m_f0 = 1'b0;
      end
    end
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (got_make && !(m_held_v && m_held == {ext, d})) begin
      m_q.push_back({1'b0, ext, d});
      m_cnt       = (m_cnt + 1) % MOD;
      m_last_code = d;
      m_last_ext  = ext;
      m_held      = {ext, d};
      m_held_v    = 1'b1;
    end
    if (got_brk) begin
      m_q.push_back({1'b1, ext, d});
      if (m_held == {ext, d}) m_held_v = 1'b0;
    end
    if (cl) begin
      m_cnt = 0;
      m_err = 1'b0;
      m_ovf = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [63:0] act, exp;
    logic [9:0]  head;
    head = (m_q.size() > 0) ? m_q[0] : 10'd0;
    act = 64'({in_ready, ev_valid, ev_data, press_bcd, last_code, last_ext,
               key_held, err, ovf});
    exp = 64'({m_q.size() < DEPTH, m_q.size() > 0, head, to_bcd(m_cnt),
               m_last_code, m_last_ext, m_held_v, m_err, m_ovf});
    check("model", act, exp);
  endtask

  // One clock: drive inputs, step the model, sample on the falling edge.
  task automatic apply(input bit rst, input bit iv, input logic [7:0] d,
                       input bit rdy, input bit cl, input bit rx);
    reset       = rst;
    in_valid    = iv;
    in_data     = d;
    ev_ready    = rdy;
    clr         = cl;
    rx_overflow = rx;
    model_step(rst, iv, d, rdy, cl, rx);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit rst; bit iv; logic [7:0] d; bit rdy; bit cl; bit rx;
    bit evv; logic [9:0] evd; logic [11:0] bcd;
    bit held; bit er; bit ov; bit lext;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input bit rst, input bit iv, input logic [7:0] d,
                      input bit rdy, input bit cl, input bit rx,
                      input bit evv, input logic [9:0] evd, input logic [11:0] bcd,
                      input bit held, input bit er, input bit ov, input bit lext);
    vec_t v;
    v = '{rst, iv, d, rdy, cl, rx, evv, evd, bcd, held, er, ov, lext};
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; ev_ready = 1'b0;
    clr = 1'b0; rx_overflow = 1'b0;
    @(negedge clk);

    // make/break of 1C with draining
    addv(1,0,8'h00,0,0,0, 0,10'h000,12'h000, 0,0,0,0);
    addv(0,1,8'h1C,1,0,0, 1,10'h01C,12'h001, 1,0,0,0);
    addv(0,1,8'hF0,1,0,0, 0,10'h000,12'h001, 1,0,0,0);
    addv(0,1,8'h1C,1,0,0, 1,10'h21C,12'h001, 0,0,0,0);
    addv(0,0,8'h00,1,0,0, 0,10'h000,12'h001, 0,0,0,0);
    // extended key with typematic repeats, then extended break
    addv(1,0,8'h00,0,0,0, 0,10'h000,12'h000, 0,0,0,0);
    addv(0,1,8'hE0,0,0,0, 0,10'h000,12'h000, 0,0,0,0);
    addv(0,1,8'h75,0,0,0, 1,10'h175,12'h001, 1,0,0,1);
    addv(0,1,8'hE0,0,0,0, 1,10'h175,12'h001, 1,0,0,1);
    addv(0,1,8'h75,0,0,0, 1,10'h175,12'h001, 1,0,0,1);
    addv(0,1,8'hE0,0,0,0, 1,10'h175,12'h001, 1,0,0,1);
    addv(0,1,8'h75,0,0,0, 1,10'h175,12'h001, 1,0,0,1);
    addv(0,1,8'hE0,0,0,0, 1,10'h175,12'h001, 1,0,0,1);
    addv(0,1,8'hF0,0,0,0, 1,10'h175,12'h001, 1,0,0,1);
    addv(0,1,8'h75,0,0,0, 1,10'h175,12'h001, 0,0,0,1);
    addv(0,0,8'h00,1,0,0, 1,10'h375,12'h001, 0,0,0,1);
    addv(0,0,8'h00,1,0,0, 0,10'h000,12'h001, 0,0,0,1);
    // F0 F0 protocol error, then clr
    addv(1,0,8'h00,0,0,0, 0,10'h000,12'h000, 0,0,0,0);
    addv(0,1,8'hF0,0,0,0, 0,10'h000,12'h000, 0,0,0,0);
    addv(0,1,8'hF0,0,0,0, 0,10'h000,12'h000, 0,1,0,0);
    addv(0,1,8'h1C,0,0,0, 1,10'h01C,12'h001, 1,1,0,0);
    addv(0,0,8'h00,0,1,0, 1,10'h01C,12'h000, 1,0,0,0);
    // reset discards pending E0 / F0 prefix
    addv(1,0,8'h00,0,0,0, 0,10'h000,12'h000, 0,0,0,0);
    addv(0,1,8'hE0,0,0,0, 0,10'h000,12'h000, 0,0,0,0);
    addv(1,0,8'h00,0,0,0, 0,10'h000,12'h000, 0,0,0,0);
    addv(0,1,8'h1C,0,0,0, 1,10'h01C,12'h001, 1,0,0,0);
    addv(0,1,8'hF0,0,0,0, 1,10'h01C,12'h001, 1,0,0,0);
    addv(1,0,8'h00,0,0,0, 0,10'h000,12'h000, 0,0,0,0);
    addv(0,1,8'h1C,0,0,0, 1,10'h01C,12'h001, 1,0,0,0);
    // rx_overflow drops the byte and the pending prefix
    addv(1,0,8'h00,0,0,0, 0,10'h000,12'h000, 0,0,0,0);
    addv(0,1,8'hE0,0,0,0, 0,10'h000,12'h000, 0,0,0,0);
    addv(0,1,8'h75,0,0,1, 0,10'h000,12'h000, 0,0,1,0);
    addv(0,1,8'h75,0,0,0, 1,10'h075,12'h001, 1,0,1,0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].cl, vecs[i].rx);
      check($sformatf("vec%0d", i),
            64'({ev_valid, ev_data, press_bcd, key_held, err, ovf, last_ext}),
            64'({vecs[i].evv, vecs[i].evd, vecs[i].bcd, vecs[i].held,
                 vecs[i].er, vecs[i].ov, vecs[i].lext}));
    end

    // FIFO fill, overflow on a held byte, ordered drain
    apply(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 8; i++) apply(0, 1, 8'(8'h10 + i), 0, 0, 0);
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_bcd", 64'(press_bcd), 64'(12'h008));
    apply(0, 1, 8'h30, 0, 0, 0);
    check("full_ovf", 64'({ovf, in_ready}), 64'(2'b10));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), 64'({ev_valid, ev_data}),
            64'({1'b1, 2'b00, 8'(8'h10 + i)}));
      apply(0, 0, 8'h00, 1, 0, 0);
    end
    check("drain_empty", 64'({ev_valid, in_ready}), 64'(2'b01));

    // 999 press/release pairs then wrap
    apply(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 999; i++) begin
      apply(0, 1, 8'(1 + i % 96), 1, 0, 0);
      apply(0, 1, 8'hF0, 1, 0, 0);
      apply(0, 1, 8'(1 + i % 96), 1, 0, 0);
    end
    check("bcd_999", 64'(press_bcd), 64'(12'h999));
    apply(0, 1, 8'h22, 1, 0, 0);
    check("bcd_wrap", 64'(press_bcd), 64'(12'h000));

    // random traffic against the model
    apply(1, 0, 8'h00, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] pool [8];
      pool = '{8'hE0, 8'hF0, 8'h1C, 8'h75, 8'h32, 8'h1C, 8'hE0, 8'hF0};
      apply($urandom_range(0, 400) == 0, $urandom_range(0, 3) != 0,
            pool[$urandom_range(0, 7)], $urandom_range(0, 2) == 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 60) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
